// File: rtl/fleet_fire_controller.sv
// -----------------------------------------------------------------------------
// fleet_fire_controller
//
// Per-fleet combat controller. It keeps one registered track per enemy
// (position, velocity, lifecycle FSM) and runs one mode FSM per own ship
// (ATTACK / DEFEND / EVADE / DEAD). Fire is aimed at each enemy's
// one-cycle-ahead predicted position. Every output is a register, so a
// response appears on the clock edge that samples the inputs.
//
// Optional feature: define COAST_PRED_EN to keep cloaked tracks alive. A
// tracked enemy that cloaks is dead-reckoned for up to COAST_MAX cycles, and
// it stays a valid fire target while it coasts. Without the macro, a cloak
// drops the track at once.
//
// Ports (ship i uses slice [i*W +: W]; enemy j uses slice [j*8 +: 8]):
//   clk              in   clock
//   reset            in   asynchronous, active-low
//   x, y             in   own ship positions, 8-bit signed each
//   energy           in   own ship energy, 8-bit unsigned each
//   destroyed        in   own ship destroyed flags
//   enemy_x_p/_y_p   in   enemy positions, 8-bit signed each
//   enemy_cloaked    in   enemy position invalid this cycle
//   enemy_destroyed  in   enemy gone
//   x_a, y_a         out  acceleration request, 4-bit signed each
//   attempt_fire/_shield/_cloak  out  action requests
//   fire_dir         out  2 bits each, 0:+x 1:-y 2:-x 3:+y
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fleet_fire_controller #(
  parameter int N_SHIPS       = 3,
  parameter int N_ENEMIES     = 3,
  parameter int E_FIRE        = 40,
  parameter int E_EVADE       = 20,
  parameter int HYST          = 4,
  parameter int FIRE_COOLDOWN = 3,
  parameter int ALIGN_TOL     = 1,
  parameter int EDGE_MARGIN   = 4,
  parameter int COAST_MAX     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SHIPS*8-1:0]   x,
  input  logic [N_SHIPS*8-1:0]   y,
  input  logic [N_SHIPS*8-1:0]   energy,
  input  logic [N_SHIPS-1:0]     destroyed,
  input  logic [N_ENEMIES*8-1:0] enemy_x_p,
  input  logic [N_ENEMIES*8-1:0] enemy_y_p,
  input  logic [N_ENEMIES-1:0]   enemy_cloaked,
  input  logic [N_ENEMIES-1:0]   enemy_destroyed,
  output logic [N_SHIPS*4-1:0]   x_a,
  output logic [N_SHIPS*4-1:0]   y_a,
  output logic [N_SHIPS-1:0]     attempt_fire,
  output logic [N_SHIPS-1:0]     attempt_shield,
  output logic [N_SHIPS-1:0]     attempt_cloak,
  output logic [N_SHIPS*2-1:0]   fire_dir
);

  localparam logic [1:0] TRK_EMPTY = 2'd0;
  localparam logic [1:0] TRK_FIRST = 2'd1;
  localparam logic [1:0] TRK_TRACK = 2'd2;
`ifdef COAST_PRED_EN
  localparam logic [1:0] TRK_COAST = 2'd3;
  localparam int         CW        = (COAST_MAX < 1) ? 1 : $clog2(COAST_MAX + 1);
`endif

  localparam logic [1:0] MODE_ATTACK = 2'd0;
  localparam logic [1:0] MODE_DEFEND = 2'd1;
  localparam logic [1:0] MODE_EVADE  = 2'd2;
  localparam logic [1:0] MODE_DEAD   = 2'd3;

  localparam int CDW = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);

  localparam logic signed [8:0] EDGE_LO   = 9'(-128 + EDGE_MARGIN);
  localparam logic signed [8:0] EDGE_HI   = 9'(127 - EDGE_MARGIN);
  localparam logic [8:0]        TOL       = 9'(ALIGN_TOL);
  localparam logic [7:0]        EN_EVADE  = 8'(E_EVADE);
  localparam logic [7:0]        EN_FIRE   = 8'(E_FIRE);
  localparam logic [7:0]        EN_RETURN = 8'(E_FIRE + HYST);

  function automatic logic [7:0] sat8(input logic signed [8:0] v);
    if (v > 9'sd127)       return 8'h7f;
    else if (v < -9'sd128) return 8'h80;
    else                   return v[7:0];
  endfunction

  function automatic logic [3:0] sat4(input logic signed [8:0] v);
    if (v > 9'sd7)       return 4'b0111;
    else if (v < -9'sd8) return 4'b1000;
    else                 return v[3:0];
  endfunction

  function automatic logic [8:0] abs9(input logic [8:0] d);
    return d[8] ? (~d + 9'd1) : d;
  endfunction

  // Push inward (+2 / -2) when within EDGE_MARGIN of either board limit.
  function automatic logic [3:0] edge_push(input logic signed [7:0] p);
    logic signed [8:0] pw;
    pw = {p[7], p};
    if (pw < EDGE_LO)      return 4'b0010;
    else if (pw > EDGE_HI) return 4'b1110;
    else                   return 4'b0000;
  endfunction

  // Predictions are formed from the track's next state, so fire decisions
  // use the enemy position sampled on the same edge.
  logic signed [7:0]    pred_x [N_ENEMIES];
  logic signed [7:0]    pred_y [N_ENEMIES];
  logic [N_ENEMIES-1:0] pred_valid;

  // ---------------------------------------------------------------- tracks
  genvar gi;
  generate
    for (gi = 0; gi < N_ENEMIES; gi++) begin : g_trk
      logic [1:0]        st_q, st_d;
      logic signed [7:0] px_q, px_d, py_q, py_d;
      logic signed [3:0] vx_q, vx_d, vy_q, vy_d;
      logic signed [7:0] cur_x, cur_y;
      logic signed [8:0] diff_x, diff_y;
`ifdef COAST_PRED_EN
      logic [CW-1:0]     cc_q, cc_d;
`endif

      assign cur_x  = enemy_x_p[gi*8 +: 8];
      assign cur_y  = enemy_y_p[gi*8 +: 8];
      assign diff_x = {cur_x[7], cur_x} - {px_q[7], px_q};
      assign diff_y = {cur_y[7], cur_y} - {py_q[7], py_q};

      always_comb begin
        st_d = st_q;
        px_d = px_q;
        py_d = py_q;
        vx_d = vx_q;
        vy_d = vy_q;
`ifdef COAST_PRED_EN
        cc_d = cc_q;
`endif
        // destroyed has priority over cloaked
        if (enemy_destroyed[gi]) begin
          st_d = TRK_EMPTY;
        end else if (!enemy_cloaked[gi]) begin
          px_d = cur_x;
          py_d = cur_y;
          if (st_q == TRK_FIRST || st_q == TRK_TRACK) begin
            st_d = TRK_TRACK;
            vx_d = sat4(diff_x);
            vy_d = sat4(diff_y);
          end else begin
            // EMPTY, or a coasting track reacquired: restart velocity
            st_d = TRK_FIRST;
            vx_d = '0;
            vy_d = '0;
          end
        end else begin
`ifdef COAST_PRED_EN
          if (st_q == TRK_TRACK || (st_q == TRK_COAST && cc_q != CW'(COAST_MAX))) begin
            st_d = TRK_COAST;
            px_d = sat8({px_q[7], px_q} + {{5{vx_q[3]}}, vx_q});
            py_d = sat8({py_q[7], py_q} + {{5{vy_q[3]}}, vy_q});
            cc_d = (st_q == TRK_TRACK) ? CW'(1) : cc_q + 1'b1;
          end else begin
            st_d = TRK_EMPTY;
          end
`else
          st_d = TRK_EMPTY;
`endif
        end
      end

      assign pred_x[gi] = sat8({px_d[7], px_d} + {{5{vx_d[3]}}, vx_d});
      assign pred_y[gi] = sat8({py_d[7], py_d} + {{5{vy_d[3]}}, vy_d});
`ifdef COAST_PRED_EN
      assign pred_valid[gi] = (st_d == TRK_TRACK) || (st_d == TRK_COAST);
`else
      assign pred_valid[gi] = (st_d == TRK_TRACK);
`endif

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          st_q <= TRK_EMPTY;
          px_q <= '0;
          py_q <= '0;
          vx_q <= '0;
          vy_q <= '0;
`ifdef COAST_PRED_EN
          cc_q <= '0;
`endif
        end else begin
          st_q <= st_d;
          px_q <= px_d;
          py_q <= py_d;
          vx_q <= vx_d;
          vy_q <= vy_d;
`ifdef COAST_PRED_EN
          cc_q <= cc_d;
`endif
        end
      end
    end
  endgenerate

  // ----------------------------------------------------------------- ships
  generate
    for (gi = 0; gi < N_SHIPS; gi++) begin : g_ship
      logic signed [7:0]    sx, sy;
      logic [7:0]           en;
      logic [1:0]           mode_q, mode_d;
      logic [CDW-1:0]       cd_q, cd_d;
      logic                 fire_q, fire_d, shield_q, shield_d, cloak_q, cloak_d;
      logic [3:0]           xa_q, xa_d, ya_q, ya_d;
      logic [1:0]           dir_q, dir_d, dir_sel;
      logic                 hit;
      logic [N_ENEMIES-1:0] al_x, al_y, ahead_x, ahead_y;

      assign sx = x[gi*8 +: 8];
      assign sy = y[gi*8 +: 8];
      assign en = energy[gi*8 +: 8];

      genvar gj;
      for (gj = 0; gj < N_ENEMIES; gj++) begin : g_cmp
        assign al_x[gj]    = pred_valid[gj] &&
                             (abs9({pred_x[gj][7], pred_x[gj]} - {sx[7], sx}) <= TOL);
        assign al_y[gj]    = pred_valid[gj] &&
                             (abs9({pred_y[gj][7], pred_y[gj]} - {sy[7], sy}) <= TOL);
        assign ahead_x[gj] = pred_x[gj] > sx;
        assign ahead_y[gj] = pred_y[gj] > sy;
      end

      // Mode FSM. In the hysteresis band (E_FIRE, E_FIRE+HYST] a ship that
      // is not already attacking sits in DEFEND, including one leaving EVADE.
      always_comb begin
        if (mode_q == MODE_DEAD || destroyed[gi])                mode_d = MODE_DEAD;
        else if (en <= EN_EVADE)                                 mode_d = MODE_EVADE;
        else if (en <= EN_FIRE)                                  mode_d = MODE_DEFEND;
        else if (mode_q == MODE_ATTACK || en > EN_RETURN)        mode_d = MODE_ATTACK;
        else                                                     mode_d = MODE_DEFEND;
      end

      // Scan high to low so the lowest-index aligned enemy wins.
      always_comb begin
        hit     = 1'b0;
        dir_sel = dir_q;
        for (int e = N_ENEMIES - 1; e >= 0; e--) begin
          if (al_x[e]) begin
            hit     = 1'b1;
            dir_sel = ahead_y[e] ? 2'd3 : 2'd1;
          end else if (al_y[e]) begin
            hit     = 1'b1;
            dir_sel = ahead_x[e] ? 2'd0 : 2'd2;
          end
        end
      end

      always_comb begin
        fire_d   = 1'b0;
        shield_d = 1'b0;
        cloak_d  = 1'b0;
        xa_d     = '0;
        ya_d     = '0;
        dir_d    = dir_q;
        cd_d     = (cd_q != '0) ? cd_q - 1'b1 : cd_q;
        case (mode_d)
          MODE_ATTACK: begin
            if (hit) begin
              dir_d = dir_sel;
              if (cd_q == '0) begin
                fire_d = 1'b1;
                cd_d   = CDW'(FIRE_COOLDOWN);
              end
            end
          end
          MODE_DEFEND: begin
            shield_d = 1'b1;
            cloak_d  = 1'b1;
          end
          MODE_EVADE: begin
            xa_d = edge_push(sx);
            ya_d = edge_push(sy);
          end
          default: dir_d = 2'd0;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mode_q   <= MODE_ATTACK;
          cd_q     <= '0;
          fire_q   <= 1'b0;
          shield_q <= 1'b0;
          cloak_q  <= 1'b0;
          xa_q     <= '0;
          ya_q     <= '0;
          dir_q    <= '0;
        end else begin
          mode_q   <= mode_d;
          cd_q     <= cd_d;
          fire_q   <= fire_d;
          shield_q <= shield_d;
          cloak_q  <= cloak_d;
          xa_q     <= xa_d;
          ya_q     <= ya_d;
          dir_q    <= dir_d;
        end
      end

      assign attempt_fire[gi]   = fire_q;
      assign attempt_shield[gi] = shield_q;
      assign attempt_cloak[gi]  = cloak_q;
      assign x_a[gi*4 +: 4]     = xa_q;
      assign y_a[gi*4 +: 4]     = ya_q;
      assign fire_dir[gi*2 +: 2] = dir_q;
    end
  endgenerate

endmodule

// File: tb/tb_fleet_fire_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for fleet_fire_controller with default parameters. Each step
// drives ship 0 / enemy 0, pushes the expected registered response into a
// scoreboard queue, then pops and compares it one clock later. Ships 1 and 2
// sit far away with full energy and must never fire. Enemies 1 and 2 stay
// destroyed. Coast expectations follow COAST_PRED_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fleet_fire_controller;

`ifdef COAST_PRED_EN
  localparam bit COAST = 1'b1;
`else
  localparam bit COAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] x, y, energy;
  logic [2:0]  destroyed;
  logic [23:0] enemy_x_p, enemy_y_p;
  logic [2:0]  enemy_cloaked, enemy_destroyed;
  logic [11:0] x_a, y_a;
  logic [2:0]  attempt_fire, attempt_shield, attempt_cloak;
  logic [5:0]  fire_dir;

  always #5 clk = ~clk;

  fleet_fire_controller dut (
    .clk            (clk),
    .reset          (reset),
    .x              (x),
    .y              (y),
    .energy         (energy),
    .destroyed      (destroyed),
    .enemy_x_p      (enemy_x_p),
    .enemy_y_p      (enemy_y_p),
    .enemy_cloaked  (enemy_cloaked),
    .enemy_destroyed(enemy_destroyed),
    .x_a            (x_a),
    .y_a            (y_a),
    .attempt_fire   (attempt_fire),
    .attempt_shield (attempt_shield),
    .attempt_cloak  (attempt_cloak),
    .fire_dir       (fire_dir)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // {ship1/2 fire, fire0, shield0, cloak0, dir0, x_a0, y_a0}
  function automatic logic [63:0] mk(input logic f, input logic sh, input logic cl,
                                     input logic [1:0] d, input logic [3:0] xa,
                                     input logic [3:0] ya);
    return {49'b0, 2'b00, f, sh, cl, d, xa, ya};
  endfunction

  function automatic logic [63:0] ship0_obs();
    return {49'b0, attempt_fire[2:1], attempt_fire[0], attempt_shield[0],
            attempt_cloak[0], fire_dir[1:0], x_a[3:0], y_a[3:0]};
  endfunction

  function automatic logic [63:0] all_obs();
    return {25'b0, x_a, y_a, attempt_fire, attempt_shield, attempt_cloak, fire_dir};
  endfunction

  task automatic expect_v(input string tag, input logic [63:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic compare(input logic [63:0] obs);
    sb_t ent;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed %h required <entry>", obs);
      return;
    end
    ent = sb_q.pop_front();
    assert (obs === ent.exp)
      else begin
        miscompares++;
        $error("FAIL %s observed %h expected %h", ent.tag, obs, ent.exp);
      end
    $display("vec %0d %s obs=%h exp=%h", vectors, ent.tag, obs, ent.exp);
  endtask

  task automatic step(input string tag, input logic [63:0] exp);
    expect_v(tag, exp);
    @(posedge clk);
    #1;
    compare(ship0_obs());
  endtask

  task automatic drive(input int sx, input int sy, input int en,
                       input int ex, input int ey, input logic ecl, input logic ede);
    x[7:0]             = 8'(sx);
    y[7:0]             = 8'(sy);
    energy[7:0]        = 8'(en);
    enemy_x_p[7:0]     = 8'(ex);
    enemy_y_p[7:0]     = 8'(ey);
    enemy_cloaked[0]   = ecl;
    enemy_destroyed[0] = ede;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    x               = {8'h9C, 8'h9C, 8'd20};
    y               = {8'h9C, 8'h9C, 8'd16};
    energy          = {3{8'd100}};
    destroyed       = 3'b000;
    enemy_x_p       = '0;
    enemy_y_p       = '0;
    enemy_cloaked   = 3'b000;
    enemy_destroyed = 3'b110;

    repeat (3) @(posedge clk);
    #1;
    expect_v("reset_state", 64'd0);
    compare(all_obs());
    @(negedge clk);
    reset = 1'b1;

    // Track build-up; prediction 16 is 4 away from ship x=20
    drive(20, 16, 100, 10, 0, 1'b0, 1'b0); step("t1_first",      mk(0, 0, 0, 2'd0, 4'h0, 4'h0));
    drive(20, 16, 100, 12, 0, 1'b0, 1'b0); step("t1_track",      mk(0, 0, 0, 2'd0, 4'h0, 4'h0));
    drive(20, 16, 100, 14, 0, 1'b0, 1'b0); step("t1_pred16_out", mk(0, 0, 0, 2'd0, 4'h0, 4'h0));

    // Aligned target for 6 cycles: fire pattern 1,0,0,0,1,0, dir -y
    for (int k = 0; k < 6; k++) begin
      drive(18 + 2 * k, 16, 100, 16 + 2 * k, 0, 1'b0, 1'b0);
      step($sformatf("t2_cooldown_k%0d", k), mk((k == 0 || k == 4), 0, 0, 2'd1, 4'h0, 4'h0));
    end

    // Energy hysteresis with no target; fire_dir holds
    drive(28, 16, 50, 0, 0, 1'b0, 1'b1); step("t3_e50_attack", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(28, 16, 30, 0, 0, 1'b0, 1'b1); step("t3_e30_defend", mk(0, 1, 1, 2'd1, 4'h0, 4'h0));
    drive(28, 16, 42, 0, 0, 1'b0, 1'b1); step("t3_e42_defend", mk(0, 1, 1, 2'd1, 4'h0, 4'h0));
    drive(28, 16, 45, 0, 0, 1'b0, 1'b1); step("t3_e45_attack", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));

    // Cloak with v=(2,0): coasting prediction 26, 28, 30 against ship x=30
    drive(30, 16, 100, 20, 0, 1'b0, 1'b0); step("t5_first",  mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(30, 16, 100, 22, 0, 1'b0, 1'b0); step("t5_track",  mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(30, 16, 100, 0, 0, 1'b1, 1'b0);  step("t5_cloak1", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(30, 16, 100, 0, 0, 1'b1, 1'b0);  step("t5_cloak2", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(30, 16, 100, 0, 0, 1'b1, 1'b0);  step("t5_cloak3", mk(COAST, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(30, 16, 100, 30, 0, 1'b0, 1'b0); step("t5_reappear", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(34, 16, 100, 32, 0, 1'b0, 1'b0); step("t5_second_visible", mk(!COAST, 0, 0, 2'd1, 4'h0, 4'h0));
    drive(36, 16, 100, 34, 0, 1'b0, 1'b0); step("t6_target_cd", mk(0, 0, 0, 2'd1, 4'h0, 4'h0));

    // Asynchronous reset mid-cooldown: outputs clear without a clock edge
    #2;
    reset = 1'b0;
    #1;
    expect_v("t6_async_reset", 64'd0);
    compare(all_obs());
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive(38, 16, 100, 36, 0, 1'b0, 1'b0); step("t6_rebuild_first", mk(0, 0, 0, 2'd0, 4'h0, 4'h0));
    drive(40, 16, 100, 38, 0, 1'b0, 1'b0); step("t6_rebuild_fire",  mk(1, 0, 0, 2'd1, 4'h0, 4'h0));

    // Jump of (12,16) saturates v to (7,7): pred (57,23) y-aligned, ahead -> +x
    drive(40, 23, 100, 50, 16, 1'b0, 1'b0); step("t7_vsat_dir0", mk(0, 0, 0, 2'd0, 4'h0, 4'h0));
    // Stationary enemy behind the ship on x: -x
    drive(60, 16, 100, 50, 16, 1'b0, 1'b0); step("t7_dir2_cd2", mk(0, 0, 0, 2'd2, 4'h0, 4'h0));
    drive(60, 16, 100, 50, 16, 1'b0, 1'b0); step("t7_dir2_cd1", mk(0, 0, 0, 2'd2, 4'h0, 4'h0));
    drive(60, 16, 100, 50, 16, 1'b0, 1'b0); step("t7_dir2_fire", mk(1, 0, 0, 2'd2, 4'h0, 4'h0));

    // EVADE near board limits, then destruction (absorbing)
    drive(125, 16, 10, 0, 0, 1'b0, 1'b1);  step("t4_evade_xhi", mk(0, 0, 0, 2'd2, 4'hE, 4'h0));
    drive(0, -126, 10, 0, 0, 1'b0, 1'b1);  step("t4_evade_ylo", mk(0, 0, 0, 2'd2, 4'h0, 4'h2));
    destroyed[0] = 1'b1;
    drive(40, 16, 100, 38, 0, 1'b0, 1'b0); step("t4_dead",        mk(0, 0, 0, 2'd0, 4'h0, 4'h0));
    destroyed[0] = 1'b0;
    drive(40, 16, 100, 40, 0, 1'b0, 1'b0); step("t4_dead_absorb", mk(0, 0, 0, 2'd0, 4'h0, 4'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
